imem_stream_loader: RTL and testbench

- Upstream boot stage for single_cycle_mips: receives a program as a byte stream and writes 32-bit instruction words into instruction memory.
- Holds the processor stalled until the image is loaded and its checksum is verified.
- Replaces the simulation-only memory preload with a synthesizable path usable from a UART or bench byte source.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/byte_word_assembler.sv | 47 ++++
 rtl/imem_stream_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_stream_loader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory stream loader.
//   state_e   : loader FSM states
//   ERR_*     : codes reported on the err output
//   HDR_BYTES : number of length bytes at the start of a frame
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenHi = 3'd1,
        StLenLo = 3'd2,
        StData  = 3'd3,
        StChk   = 3'd4,
        StDone  = 3'd5,
        StErr   = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream, MSB first, into 32-bit words.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : drop any partial word (takes priority over strobe)
//   strobe       : in_byte is accepted this cycle
//   in_byte      : stream byte
//   word         : assembled word, valid while word_valid is high
//   word_valid   : high in the cycle the 4th byte of a word is accepted
module byte_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (strobe) begin
            shift_d = {shift_q[15:0], in_byte};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // The 4th byte completes the word combinationally; the caller registers it.
    assign word       = {shift_q, in_byte};
    assign word_valid = strobe && !clear && (cnt_q == 2'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame and writes
// the contained 32-bit words into instruction memory, holding the CPU until done.
//   clock, reset         : clock and asynchronous active-high reset
//   start                : pulse; begins a load from IDLE, DONE or ERR
//   in_data/valid/ready  : byte stream handshake
//   imem_we/addr/wdata   : instruction memory write port
//   cpu_hold             : processor stall
//   done, err            : load status levels
//   words_loaded         : words written by the current or last load
module imem_stream_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

    state_e              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [7:0]          csum_q, csum_d;
    logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic [ADDR_W:0]     words_q, words_d;

    logic        accept;
    logic        asm_clear;
    logic [31:0] asm_word;
    logic        asm_word_valid;
    logic [16:0] len_full;

    assign in_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                      (state_q == StData)  || (state_q == StChk);
    assign accept   = in_valid && in_ready;
    assign len_full = {1'b0, len_hi_q, in_data};

    byte_word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear),
        .strobe     (accept && (state_q == StData)),
        .in_byte    (in_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        csum_d    = csum_q;
        wr_idx_d  = wr_idx_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;
        words_d   = words_q;
        asm_clear = 1'b0;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d   = StLenHi;
                    done_d    = 1'b0;
                    err_d     = ERR_NONE;
                    words_d   = '0;
                    csum_d    = '0;
                    hold_d    = 1'b1;
                    wr_idx_d  = '0;
                    asm_clear = 1'b1;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = in_data;
                    csum_d   = csum_q ^ in_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    len_d  = len_full[ADDR_W:0];
                    if (len_full > CAPACITY) begin
                        state_d = StErr;
                        err_d   = ERR_LEN;
                    end else if (len_full == 17'd0) begin
                        state_d = StChk;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (asm_word_valid) begin
                        we_d     = 1'b1;
                        addr_d   = wr_idx_q;
                        wdata_d  = asm_word;
                        wr_idx_d = wr_idx_q + 1'b1;
                        words_d  = words_q + 1'b1;
                        if (words_q + 1'b1 == len_q) begin
                            state_d = StChk;
                        end
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = ERR_CSUM;
                        hold_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            len_hi_q <= '0;
            len_q    <= '0;
            csum_q   <= '0;
            wr_idx_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            csum_q   <= csum_d;
            wr_idx_q <= wr_idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
            words_q  <= words_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: frames are built here, pushed through
// the byte handshake, and the observed memory writes and status are compared with
// a frame-level reference model.
module tb_imem_stream_loader;
    import loader_pkg::*;

    localparam int AW  = 10;
    localparam int CAP = 1 << AW;

    logic          clock;
    logic          reset;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic [1:0]    err;
    logic [AW:0]   words_loaded;

    imem_stream_loader #(
        .ADDR_W (AW),
        .DATA_W (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int   errors = 0;
    int   checks = 0;
    int   xfers  = 0;
    wr_t  act_q[$];
    wr_t  exp_q[$];
    logic [7:0] frame_q[$];

    logic       exp_done;
    logic [1:0] exp_err;
    int         exp_words;

    // Write monitor and transfer counter.
    always @(negedge clock) begin
        if (!reset && imem_we) act_q.push_back({imem_addr, imem_wdata});
    end
    always @(posedge clock) begin
        if (in_valid && in_ready) xfers <= xfers + 1;
    end

    // Frame-level reference: length header, big-endian words, XOR checksum.
    task automatic model();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        exp_q.delete();
        n = {frame_q[0], frame_q[1]};
        if (n > CAP) begin
            exp_done = 1'b0; exp_err = 2'b01; exp_words = 0;
            return;
        end
        x = frame_q[0] ^ frame_q[1];
        for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                w = (w << 8) | 32'(frame_q[HDR_BYTES + 4 * i + b]);
                x = x ^ frame_q[HDR_BYTES + 4 * i + b];
            end
            exp_q.push_back({AW'(i), w});
        end
        exp_words = n;
        if (frame_q[HDR_BYTES + 4 * n] == x) begin
            exp_done = 1'b1; exp_err = 2'b00;
        end else begin
            exp_done = 1'b0; exp_err = 2'b10;
        end
    endtask

    task automatic build_frame(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        x = frame_q[0] ^ frame_q[1];
        if (n > CAP) return;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x = x ^ b;
        end
        frame_q.push_back(good ? x : (x ^ (8'h01 << $urandom_range(0, 7))));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_byte: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 2'b00 || words_loaded !== '0) begin
            errors++;
            $display("FAIL start_clear: hold=%b done=%b err=%b words=%0d, required 1 0 00 0",
                     cpu_hold, done, err, words_loaded);
        end
    endtask

    // Sends frame_q; start_at >= 0 pulses start just before that byte index.
    task automatic run_frame(input string name, input int gap_max, input int start_at);
        int x0;
        act_q.delete();
        do_start();
        x0 = xfers;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == start_at) begin
                @(negedge clock); start = 1'b1;
                @(negedge clock); start = 1'b0;
            end
            send_byte(frame_q[i], $urandom_range(0, gap_max));
        end
        repeat (3) @(negedge clock);
        model();
        checks++;
        if (done !== exp_done || err !== exp_err || cpu_hold !== !exp_done) begin
            errors++;
            $display("FAIL %s status: done=%b err=%b hold=%b, required %b %b %b", name,
                     done, err, cpu_hold, exp_done, exp_err, !exp_done);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready: got %b, required 0", name, in_ready);
        end
        checks++;
        if (words_loaded !== (AW + 1)'(exp_words)) begin
            errors++;
            $display("FAIL %s words_loaded: got %0d, required %0d", name, words_loaded, exp_words);
        end
        checks++;
        if (xfers - x0 != frame_q.size()) begin
            errors++;
            $display("FAIL %s transfers: got %0d, required %0d", name, xfers - x0, frame_q.size());
        end
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d, required %0d", name, act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s write[%0d]: got %h, required addr=%0d data=%h", name, i,
                         (i < act_q.size()) ? act_q[i] : '0, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0 ||
            cpu_hold !== 1'b1 || done !== 1'b0 || err !== 2'b00 || words_loaded !== '0) begin
            errors++;
            $display("FAIL %s: rdy=%b we=%b addr=%0d wdata=%h hold=%b done=%b err=%b words=%0d, required 0 0 0 0 1 0 00 0",
                     name, in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err,
                     words_loaded);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        check_reset_values("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_basic();
        frame_q = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h8B};
        run_frame("basic", 0, -1);
    endtask

    task automatic test_bad_checksum();
        frame_q = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("bad_csum", 0, -1);
    endtask

    task automatic test_len_overflow();
        int x0;
        frame_q = '{8'h04, 8'h01};
        run_frame("len_overflow", 0, -1);
        // Bytes offered in ERR must not be consumed.
        x0 = xfers;
        @(negedge clock);
        in_data = 8'hA5; in_valid = 1'b1;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        checks++;
        if (xfers != x0 || err !== 2'b01 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL err_no_consume: xfers=%0d err=%b, required %0d 01", xfers, err, x0);
        end
    endtask

    task automatic test_zero_length();
        frame_q = '{8'h00, 8'h00, 8'h00};
        run_frame("zero_len", 0, -1);
    endtask

    task automatic test_valid_gaps();
        frame_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        frame_q[6] = 8'h01 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
        act_q.delete();
        do_start();
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 2);
        repeat (3) @(negedge clock);
        checks++;
        if (act_q.size() != 1 || act_q[0] !== {AW'(0), 32'hDEADBEEF} || done !== 1'b1) begin
            errors++;
            $display("FAIL valid_gaps: writes=%0d first=%h done=%b, required 1 addr0 DEADBEEF 1",
                     act_q.size(), (act_q.size() > 0) ? act_q[0] : '0, done);
        end
        run_frame("gaps_random", 3, -1);
    endtask

    task automatic test_start_ignored();
        build_frame(3, 1'b1);
        run_frame("start_ignored", 1, 5);
    endtask

    task automatic test_reset_mid_frame();
        act_q.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_values("reset_mid_frame");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (act_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_write: got %0d writes, required 0", act_q.size());
        end
        build_frame(1, 1'b1);
        run_frame("after_reset", 0, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            build_frame($urandom_range(1, 12), ($urandom_range(0, 3) != 0));
            run_frame("random", 3, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : -1);
        end
    endtask

    task automatic test_max_length();
        build_frame(CAP, 1'b1);
        run_frame("max_len", 0, -1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_len_overflow();
        test_zero_length();
        test_valid_gaps();
        test_start_ignored();
        test_reset_mid_frame();
        test_random();
        test_max_length();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
